// File: rtl/scd_pkg.sv
// Shared definitions for the SC-decoder frame scheduler.
// Holds the scheduler state encoding, the default code geometry
// (log2 code length, LLR width, requester count), the derived frame and
// requester-ID widths, and the watchdog counter width.
package scd_pkg;

  // Requester-ID width: at least one bit even for a single requester.
  function automatic int idw_of(input int r);
    return (r < 2) ? 1 : $clog2(r);
  endfunction

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    RUN     = 3'd2,
    CAPTURE = 3'd3,
    RESP    = 3'd4
  } sched_state_t;

  localparam int SCD_LOG2N   = 4;
  localparam int SCD_N       = 1 << SCD_LOG2N;
  localparam int SCD_Q       = 6;
  localparam int SCD_FRAME_W = SCD_N * SCD_Q;
  localparam int SCD_R       = 2;
  localparam int SCD_IDW     = idw_of(SCD_R);
  localparam int WD_W        = 16;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Ports:
//   req_i       - pending request vector, one bit per requester
//   last_i      - index of the most recently granted requester
//   gnt_o       - one-hot grant
//   gnt_idx_o   - index of the granted requester
//   gnt_valid_o - at least one request is pending
// The search starts at (last_i + 1) mod R and wraps, so the previous winner
// has the lowest priority.
module rr_arbiter #(
  parameter int R   = 2,
  parameter int IDW = 1
) (
  input  logic [R-1:0]   req_i,
  input  logic [IDW-1:0] last_i,
  output logic [R-1:0]   gnt_o,
  output logic [IDW-1:0] gnt_idx_o,
  output logic           gnt_valid_o
);

  int idx_s;

  // First pending requester after the last winner, with wrap-around.
  always_comb begin
    gnt_o       = '0;
    gnt_idx_o   = '0;
    gnt_valid_o = 1'b0;
    idx_s       = 0;
    for (int k = 1; k <= R; k++) begin
      idx_s = (int'(last_i) + k) % R;
      if (!gnt_valid_o && req_i[idx_s]) begin
        gnt_valid_o   = 1'b1;
        gnt_o[idx_s]  = 1'b1;
        gnt_idx_o     = IDW'(idx_s);
      end else begin
        gnt_valid_o   = gnt_valid_o;
      end
    end
  end

endmodule

// File: rtl/scd_frame_scheduler.sv
// Shares one successive-cancellation decoder core between R requesters.
// Ports:
//   clk, rst_n        - clock, asynchronous active-low reset
//   req_valid_i/_llr_i - per-requester frame request and its N*Q-bit LLR frame
//   req_ready_o       - one-hot acceptance strobe (IDLE only)
//   dec_llr_o, dec_llr_valid_o, dec_en_o - drive the decoder core
//   dec_busy_i, dec_done_i, dec_code_i   - status/result from the core
//   res_valid_o/res_ready_i - result handshake
//   res_code_o, res_id_o, res_timeout_o  - decoded word, requester, abort flag
//   sched_busy_o      - scheduler is not IDLE
// Flow: IDLE -> LOAD -> RUN -> CAPTURE -> RESP -> IDLE, with a watchdog
// that forces CAPTURE (abort) when RUN lasts too long.
module scd_frame_scheduler
  import scd_pkg::*;
#(
  parameter int  n       = SCD_LOG2N,
  parameter int  Q       = SCD_Q,
  parameter int  R       = SCD_R,
  parameter int  TIMEOUT = 1023,
  localparam int N       = 1 << n,
  localparam int FW      = N * Q,
  localparam int IDW     = idw_of(R)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [R-1:0]    req_valid_i,
  input  logic [R*FW-1:0] req_llr_i,
  output logic [R-1:0]    req_ready_o,
  output logic [FW-1:0]   dec_llr_o,
  output logic            dec_llr_valid_o,
  output logic            dec_en_o,
  input  logic            dec_busy_i,
  input  logic            dec_done_i,
  input  logic [N-1:0]    dec_code_i,
  output logic            res_valid_o,
  input  logic            res_ready_i,
  output logic [N-1:0]    res_code_o,
  output logic [IDW-1:0]  res_id_o,
  output logic            res_timeout_o,
  output logic            sched_busy_o
);

  sched_state_t   state_q, state_d;
  logic [IDW-1:0] last_q, last_d;
  logic [FW-1:0]  frame_q, frame_d;
  logic [IDW-1:0] id_q, id_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic           abort_q, abort_d;
  logic [N-1:0]   code_q, code_d;
  logic           tout_q, tout_d;

  logic [R-1:0]   gnt_s;
  logic [IDW-1:0] gnt_idx_s;
  logic           gnt_valid_s;

  rr_arbiter #(.R(R), .IDW(IDW)) u_arb (
    .req_i       (req_valid_i),
    .last_i      (last_q),
    .gnt_o       (gnt_s),
    .gnt_idx_o   (gnt_idx_s),
    .gnt_valid_o (gnt_valid_s)
  );

  // State and datapath registers; last_q resets to R-1 so requester 0 wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= IDW'(R - 1);
      frame_q <= '0;
      id_q    <= '0;
      wd_q    <= '0;
      abort_q <= 1'b0;
      code_q  <= '0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      frame_q <= frame_d;
      id_q    <= id_d;
      wd_q    <= wd_d;
      abort_q <= abort_d;
      code_q  <= code_d;
      tout_q  <= tout_d;
    end
  end

  // Next-state logic and decoder/result port decode.
  always_comb begin
    state_d         = state_q;
    last_d          = last_q;
    frame_d         = frame_q;
    id_d            = id_q;
    wd_d            = wd_q;
    abort_d         = abort_q;
    code_d          = code_q;
    tout_d          = tout_q;
    req_ready_o     = '0;
    dec_llr_o       = '0;
    dec_llr_valid_o = 1'b0;
    dec_en_o        = 1'b0;
    res_valid_o     = 1'b0;
    case (state_q)
      IDLE: begin
        // A busy core has not released the previous frame yet.
        if (gnt_valid_s && !dec_busy_i) begin
          req_ready_o = gnt_s;
          frame_d     = req_llr_i[int'(gnt_idx_s) * FW +: FW];
          id_d        = gnt_idx_s;
          last_d      = gnt_idx_s;
          state_d     = LOAD;
        end else begin
          state_d     = IDLE;
        end
      end
      LOAD: begin
        dec_llr_valid_o = 1'b1;
        dec_en_o        = 1'b1;
        dec_llr_o       = frame_q;
        wd_d            = '0;
        abort_d         = 1'b0;
        state_d         = RUN;
      end
      RUN: begin
        // Enable drops in the done cycle itself; done beats a coincident timeout.
        dec_en_o = !dec_done_i;
        wd_d     = wd_q + 16'd1;
        if (dec_done_i) begin
          state_d = CAPTURE;
        end else if (wd_q == WD_W'(TIMEOUT)) begin
          abort_d = 1'b1;
          state_d = CAPTURE;
        end else begin
          state_d = RUN;
        end
      end
      CAPTURE: begin
        code_d  = abort_q ? '0 : dec_code_i;
        tout_d  = abort_q;
        state_d = RESP;
      end
      RESP: begin
        res_valid_o = 1'b1;
        if (res_ready_i) begin
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign res_code_o    = code_q;
  assign res_id_o      = id_q;
  assign res_timeout_o = tout_q;
  assign sched_busy_o  = (state_q != IDLE);

endmodule

// File: tb/tb_scd_frame_scheduler.sv
`timescale 1ns/1ps
module tb_scd_frame_scheduler;

  localparam int LN   = 4;
  localparam int Q    = 6;
  localparam int R    = 2;
  localparam int N    = 16;
  localparam int FW   = N * Q;
  localparam int IDW  = 1;
  localparam int TO_L = 1023;
  localparam int TO_S = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic            sel;
  logic [R-1:0]    req_valid;
  logic [R*FW-1:0] req_llr;
  logic            dec_busy;
  logic            dec_done;
  logic [N-1:0]    dec_code;
  logic            res_ready;

  logic [R-1:0]   rqv_l, rqv_s, rr_l, rr_s;
  logic [FW-1:0]  dl_l, dl_s;
  logic           dv_l, dv_s, de_l, de_s, rv_l, rv_s, rt_l, rt_s, sb_l, sb_s;
  logic [N-1:0]   rc_l, rc_s;
  logic [IDW-1:0] ri_l, ri_s;

  // The unselected instance sees no requests and so stays idle.
  assign rqv_l = sel ? '0 : req_valid;
  assign rqv_s = sel ? req_valid : '0;

  logic [R-1:0]   req_ready_m;
  logic [FW-1:0]  dec_llr_m;
  logic           dec_llr_valid_m, dec_en_m, res_valid_m, res_timeout_m, busy_m;
  logic [N-1:0]   res_code_m;
  logic [IDW-1:0] res_id_m;
  assign req_ready_m     = sel ? rr_s : rr_l;
  assign dec_llr_m       = sel ? dl_s : dl_l;
  assign dec_llr_valid_m = sel ? dv_s : dv_l;
  assign dec_en_m        = sel ? de_s : de_l;
  assign res_valid_m     = sel ? rv_s : rv_l;
  assign res_code_m      = sel ? rc_s : rc_l;
  assign res_id_m        = sel ? ri_s : ri_l;
  assign res_timeout_m   = sel ? rt_s : rt_l;
  assign busy_m          = sel ? sb_s : sb_l;

  scd_frame_scheduler #(.n(LN), .Q(Q), .R(R), .TIMEOUT(TO_L)) dut_l (
    .clk(clk), .rst_n(rst_n), .req_valid_i(rqv_l), .req_llr_i(req_llr),
    .req_ready_o(rr_l), .dec_llr_o(dl_l), .dec_llr_valid_o(dv_l), .dec_en_o(de_l),
    .dec_busy_i(dec_busy), .dec_done_i(dec_done), .dec_code_i(dec_code),
    .res_valid_o(rv_l), .res_ready_i(res_ready), .res_code_o(rc_l), .res_id_o(ri_l),
    .res_timeout_o(rt_l), .sched_busy_o(sb_l));

  scd_frame_scheduler #(.n(LN), .Q(Q), .R(R), .TIMEOUT(TO_S)) dut_s (
    .clk(clk), .rst_n(rst_n), .req_valid_i(rqv_s), .req_llr_i(req_llr),
    .req_ready_o(rr_s), .dec_llr_o(dl_s), .dec_llr_valid_o(dv_s), .dec_en_o(de_s),
    .dec_busy_i(dec_busy), .dec_done_i(dec_done), .dec_code_i(dec_code),
    .res_valid_o(rv_s), .res_ready_i(res_ready), .res_code_o(rc_s), .res_id_o(ri_s),
    .res_timeout_o(rt_s), .sched_busy_o(sb_s));

  int checks;
  int errors;

  // Reference "decoding": XOR-fold of the frame into N bits.
  function automatic logic [N-1:0] fold(input logic [FW-1:0] f);
    logic [N-1:0] a;
    a = '0;
    for (int i = 0; i < FW / N; i++) a = a ^ f[i*N +: N];
    return a;
  endfunction

  // Decoder core model: done pulses dec_lat cycles after the LLR load cycle
  // (dec_lat 0 = never). Code is either fixed or the fold of the loaded frame.
  int           dcnt;
  int           dec_lat;
  bit           rand_lat;
  bit           use_fixed;
  logic [N-1:0] fixed_code;
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dcnt     <= 0;
      dec_done <= 1'b0;
      dec_code <= '0;
    end else begin
      dec_done <= 1'b0;
      if (dec_llr_valid_m) begin
        dcnt     <= rand_lat ? int'($urandom_range(12, 1)) : dec_lat;
        dec_code <= use_fixed ? fixed_code : fold(dec_llr_m);
      end else if (dcnt > 0) begin
        dcnt <= dcnt - 1;
        if (dcnt == 1) dec_done <= 1'b1;
      end
    end
  end

  task automatic apply_reset();
    req_valid = '0;
    res_ready = 1'b1;
    dec_busy  = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_idle(input string tag);
    bit ok;
    ok = 1'b0;
    res_ready = 1'b1;
    req_valid = '0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk); #1;
      if (!busy_m) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL %s_drain: still busy after 2000 cycles", tag); end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({rr_l, dl_l, dv_l, de_l, rv_l, rc_l, ri_l, rt_l, sb_l} !== '0) begin
      errors++; $display("FAIL reset_outputs_l: got nonzero outputs busy=%b en=%b rv=%b", sb_l, de_l, rv_l);
    end
    checks++;
    if ({rr_s, dl_s, dv_s, de_s, rv_s, rc_s, ri_s, rt_s, sb_s} !== '0) begin
      errors++; $display("FAIL reset_outputs_s: got nonzero outputs busy=%b en=%b rv=%b", sb_s, de_s, rv_s);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    logic [FW-1:0] frame, llr_seen;
    logic [N-1:0]  code;
    logic [IDW-1:0] id;
    logic          to;
    int rdy0, rdy1, lv, en_cnt, acc, rlat;
    bit got;
    sel = 1'b0; use_fixed = 1'b1; fixed_code = 16'hA5C3; rand_lat = 1'b0; dec_lat = 40;
    res_ready = 1'b1;
    frame = {$urandom(), $urandom(), $urandom()};
    req_llr = {$urandom(), $urandom(), $urandom(), frame};
    rdy0 = 0; rdy1 = 0; lv = 0; en_cnt = 0; acc = -1; rlat = -1; got = 1'b0;
    llr_seen = '0; code = '0; id = '0; to = 1'b0;
    @(negedge clk);
    req_valid = 2'b01;
    for (int c = 0; c < 80; c++) begin
      if (c > 0) @(negedge clk);
      if (rdy0 > 0) req_valid = 2'b00;
      #1;
      if (req_ready_m[0]) begin rdy0++; acc = c; end
      if (req_ready_m[1]) rdy1++;
      if (dec_llr_valid_m) begin lv++; llr_seen = dec_llr_m; end
      if (dec_en_m) en_cnt++;
      if (res_valid_m && !got) begin
        got = 1'b1; rlat = c - acc; code = res_code_m; id = res_id_m; to = res_timeout_m;
      end
    end
    checks++; if (rdy0 !== 1) begin errors++; $display("FAIL single_ready0: pulses %0d want 1", rdy0); end
    checks++; if (rdy1 !== 0) begin errors++; $display("FAIL single_ready1: pulses %0d want 0", rdy1); end
    checks++; if (lv !== 1) begin errors++; $display("FAIL single_llr_valid: pulses %0d want 1", lv); end
    checks++; if (llr_seen !== frame) begin errors++; $display("FAIL single_llr: got %h want %h", llr_seen, frame); end
    checks++; if (!got) begin errors++; $display("FAIL single_result: res_valid got 0 want 1"); end
    checks++; if (rlat !== 1 + 40 + 2) begin errors++; $display("FAIL single_latency: got %0d want %0d", rlat, 43); end
    checks++; if (en_cnt !== 40) begin errors++; $display("FAIL single_en_cycles: got %0d want 40", en_cnt); end
    checks++; if (code !== 16'hA5C3) begin errors++; $display("FAIL single_code: got %h want a5c3", code); end
    checks++; if (id !== 1'b0) begin errors++; $display("FAIL single_id: got %0d want 0", id); end
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL single_timeout: got %b want 0", to); end
    wait_idle("single");
  endtask

  task automatic test_alternate();
    logic [FW-1:0] f0, f1;
    int gq[$];
    int iq[$];
    logic [N-1:0] cq[$];
    apply_reset();
    sel = 1'b0; use_fixed = 1'b0; rand_lat = 1'b0; dec_lat = 6; res_ready = 1'b1;
    f0 = {$urandom(), $urandom(), $urandom()};
    f1 = {$urandom(), $urandom(), $urandom()};
    req_llr = {f1, f0};
    @(negedge clk);
    req_valid = 2'b11;
    for (int c = 0; c < 400 && iq.size() < 4; c++) begin
      if (gq.size() >= 4) req_valid = 2'b00;
      #1;
      if (req_ready_m != 2'b00) gq.push_back(req_ready_m == 2'b10 ? 1 : 0);
      if (res_valid_m && res_ready) begin iq.push_back(int'(res_id_m)); cq.push_back(res_code_m); end
      @(negedge clk);
    end
    checks++; if (gq.size() != 4) begin errors++; $display("FAIL alt_grants: got %0d want 4", gq.size()); end
    checks++; if (iq.size() != 4) begin errors++; $display("FAIL alt_results: got %0d want 4", iq.size()); end
    for (int i = 0; i < gq.size() && i < 4; i++) begin
      checks++; if (gq[i] != i % 2) begin errors++; $display("FAIL alt_grant%0d: got %0d want %0d", i, gq[i], i % 2); end
    end
    for (int i = 0; i < iq.size(); i++) begin
      checks++; if (iq[i] != i % 2) begin errors++; $display("FAIL alt_id%0d: got %0d want %0d", i, iq[i], i % 2); end
      checks++;
      if (cq[i] !== fold((i % 2 == 1) ? f1 : f0)) begin
        errors++; $display("FAIL alt_code%0d: got %h want %h", i, cq[i], fold((i % 2 == 1) ? f1 : f0));
      end
    end
    wait_idle("alt");
  endtask

  task automatic test_backpressure();
    logic [FW-1:0] f0;
    logic [N-1:0] scode;
    logic [IDW-1:0] sid;
    logic sto;
    bit seen, acc;
    sel = 1'b0; use_fixed = 1'b0; rand_lat = 1'b0; dec_lat = 5; res_ready = 1'b0;
    f0 = {$urandom(), $urandom(), $urandom()};
    req_llr = {$urandom(), $urandom(), $urandom(), f0};
    seen = 1'b0; acc = 1'b0;
    @(negedge clk);
    req_valid = 2'b01;
    for (int c = 0; c < 100; c++) begin
      if (acc) req_valid = 2'b10;
      #1;
      if (req_ready_m[0]) acc = 1'b1;
      if (res_valid_m) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    checks++; if (!seen) begin errors++; $display("FAIL bp_result: res_valid got 0 want 1"); end
    scode = res_code_m; sid = res_id_m; sto = res_timeout_m;
    checks++; if (scode !== fold(f0)) begin errors++; $display("FAIL bp_code: got %h want %h", scode, fold(f0)); end
    checks++; if (sid !== 1'b0 || sto !== 1'b0) begin errors++; $display("FAIL bp_id_to: got %0d/%b want 0/0", sid, sto); end
    for (int c = 0; c < 20; c++) begin
      @(negedge clk); #1;
      checks++;
      if (!(res_valid_m === 1'b1 && res_code_m === scode && res_id_m === sid && res_timeout_m === sto &&
            req_ready_m === 2'b00 && dec_llr_valid_m === 1'b0 && dec_en_m === 1'b0)) begin
        errors++;
        $display("FAIL bp_hold%0d: got rv=%b code=%h rdy=%b lv=%b en=%b want rv=1 code=%h rdy=00 lv=0 en=0",
                 c, res_valid_m, res_code_m, req_ready_m, dec_llr_valid_m, dec_en_m, scode);
      end
    end
    @(negedge clk);
    res_ready = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (req_ready_m !== 2'b10 || res_valid_m !== 1'b0) begin
      errors++; $display("FAIL bp_release: got rdy=%b rv=%b want rdy=10 rv=0", req_ready_m, res_valid_m);
    end
    @(negedge clk);
    wait_idle("bp");
  endtask

  task automatic test_busy_block();
    sel = 1'b0; dec_busy = 1'b1; dec_lat = 5;
    @(negedge clk);
    req_valid = 2'b11;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if (req_ready_m !== 2'b00 || busy_m !== 1'b0) begin
        errors++; $display("FAIL busy_block%0d: got rdy=%b busy=%b want 00/0", c, req_ready_m, busy_m);
      end
      @(negedge clk);
    end
    dec_busy = 1'b0;
    #1;
    checks++;
    if (req_ready_m !== 2'b01) begin errors++; $display("FAIL busy_release: got rdy=%b want 01", req_ready_m); end
    @(negedge clk);
    wait_idle("busy");
  endtask

  task automatic test_watchdog();
    int lats[5] = '{0, 5, 15, 16, 17};
    int L, acc, rlat, en_cnt, exp_lat, exp_en;
    bit normal, got;
    logic [N-1:0] code, exp_code;
    logic [IDW-1:0] id;
    logic to;
    sel = 1'b1; use_fixed = 1'b1; rand_lat = 1'b0; res_ready = 1'b1;
    for (int t = 0; t < 5; t++) begin
      L = lats[t];
      dec_lat = L;
      fixed_code = 16'($urandom()) | 16'h0001;
      normal = (L >= 1) && (L <= TO_S + 1);
      exp_lat  = normal ? L + 3 : TO_S + 4;
      exp_en   = normal ? L : TO_S + 2;
      exp_code = normal ? fixed_code : 16'h0000;
      acc = -1; rlat = -1; en_cnt = 0; got = 1'b0; code = '0; id = '0; to = 1'b0;
      @(negedge clk);
      req_valid = 2'b01;
      for (int c = 0; c < 30; c++) begin
        if (c > 0) @(negedge clk);
        if (acc >= 0) req_valid = 2'b00;
        #1;
        if (req_ready_m[0] && acc < 0) acc = c;
        if (dec_en_m) en_cnt++;
        if (res_valid_m && !got) begin
          got = 1'b1; rlat = c - acc; code = res_code_m; id = res_id_m; to = res_timeout_m;
        end
      end
      checks++; if (!got) begin errors++; $display("FAIL wd%0d_result: res_valid got 0 want 1", L); end
      checks++; if (rlat !== exp_lat) begin errors++; $display("FAIL wd%0d_latency: got %0d want %0d", L, rlat, exp_lat); end
      checks++; if (en_cnt !== exp_en) begin errors++; $display("FAIL wd%0d_en_cycles: got %0d want %0d", L, en_cnt, exp_en); end
      checks++; if (code !== exp_code) begin errors++; $display("FAIL wd%0d_code: got %h want %h", L, code, exp_code); end
      checks++; if (to !== !normal) begin errors++; $display("FAIL wd%0d_timeout: got %b want %b", L, to, !normal); end
      checks++; if (id !== 1'b0) begin errors++; $display("FAIL wd%0d_id: got %0d want 0", L, id); end
    end
    wait_idle("wd");
    sel = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    bit acc;
    sel = 1'b0; use_fixed = 1'b1; fixed_code = 16'h1234; rand_lat = 1'b0; dec_lat = 0;
    acc = 1'b0;
    @(negedge clk);
    req_valid = 2'b10;
    for (int c = 0; c < 10 && !acc; c++) begin
      #1;
      if (req_ready_m[1]) acc = 1'b1;
      @(negedge clk);
    end
    req_valid = 2'b00;
    repeat (5) @(negedge clk);
    #1;
    checks++; if (dec_en_m !== 1'b1) begin errors++; $display("FAIL rst_run_en: got %b want 1", dec_en_m); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({rr_l, dl_l, dv_l, de_l, rv_l, rc_l, ri_l, rt_l, sb_l} !== '0) begin
      errors++; $display("FAIL rst_async: got busy=%b en=%b rv=%b want all 0", sb_l, de_l, rv_l);
    end
    @(negedge clk);
    rst_n = 1'b1;
    dec_lat = 4;
    req_valid = 2'b11;
    #1;
    checks++; if (req_ready_m !== 2'b01) begin errors++; $display("FAIL rst_first_grant: got %b want 01", req_ready_m); end
    @(negedge clk);
    wait_idle("rst");
  endtask

  task automatic test_random();
    int last_m, exp_idx, nfr;
    bit in_flight;
    logic [R-1:0] exp_rdy;
    logic [FW-1:0] exp_frame;
    logic [IDW-1:0] exp_id;
    apply_reset();
    sel = 1'b0; use_fixed = 1'b0; rand_lat = 1'b1;
    last_m = R - 1; in_flight = 1'b0; nfr = 0; exp_frame = '0; exp_id = '0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      req_valid = R'($urandom_range(3, 0));
      req_llr   = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      res_ready = ($urandom_range(3, 0) != 0);
      #1;
      exp_rdy = '0;
      exp_idx = -1;
      if (!in_flight) begin
        for (int k = 1; k <= R; k++) begin
          if (exp_idx < 0 && req_valid[(last_m + k) % R]) exp_idx = (last_m + k) % R;
        end
      end
      if (exp_idx >= 0) exp_rdy[exp_idx] = 1'b1;
      checks++;
      if (req_ready_m !== exp_rdy) begin errors++; $display("FAIL rnd_grant c%0d: got %b want %b", c, req_ready_m, exp_rdy); end
      if (exp_idx >= 0) begin
        exp_frame = req_llr[exp_idx*FW +: FW];
        exp_id = IDW'(exp_idx);
        last_m = exp_idx;
        in_flight = 1'b1;
        nfr++;
      end
      if (dec_llr_valid_m) begin
        checks++;
        if (dec_llr_m !== exp_frame) begin errors++; $display("FAIL rnd_llr c%0d: got %h want %h", c, dec_llr_m, exp_frame); end
      end
      if (res_valid_m && res_ready) begin
        checks++;
        if (res_id_m !== exp_id || res_code_m !== fold(exp_frame) || res_timeout_m !== 1'b0) begin
          errors++;
          $display("FAIL rnd_result c%0d: got id=%0d code=%h to=%b want id=%0d code=%h to=0",
                   c, res_id_m, res_code_m, res_timeout_m, exp_id, fold(exp_frame));
        end
        in_flight = 1'b0;
      end
    end
    checks++; if (nfr < 10) begin errors++; $display("FAIL rnd_frames: got %0d want >=10", nfr); end
    rand_lat = 1'b0;
    wait_idle("rnd");
  endtask

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0; sel = 1'b0; req_valid = '0; req_llr = '0; dec_busy = 1'b0; res_ready = 1'b1;
    dec_lat = 0; rand_lat = 1'b0; use_fixed = 1'b0; fixed_code = '0;
    test_reset();
    test_single();
    test_alternate();
    test_backpressure();
    test_busy_block();
    test_watchdog();
    test_reset_mid_run();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded 50000 cycles");
    $fatal(1, "bench time limit");
  end

endmodule
